// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single shared memory port.
// Grants one owner at a time, with burst lock and wait timeout.
`ifndef TYPE_BW
`define TYPE_BW 32
`endif

module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
`ifdef USE_POWER_PINS
    inout  wire                  vccd1,
    inout  wire                  vssd1,
`endif
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           m0_operation,
    input  logic [31:0]          m0_addr,
    input  logic [`TYPE_BW-1:0]  m0_wdata,
    output logic [`TYPE_BW-1:0]  m0_rdata,
    output logic                 m0_opdone,
    input  logic [1:0]           m1_operation,
    input  logic [31:0]          m1_addr,
    input  logic [`TYPE_BW-1:0]  m1_wdata,
    output logic [`TYPE_BW-1:0]  m1_rdata,
    output logic                 m1_opdone,
    output logic [1:0]           mem_operation,
    output logic [31:0]          addr_o,
    output logic [`TYPE_BW-1:0]  data_o,
    input  logic [`TYPE_BW-1:0]  data_i,
    input  logic                 mem_opdone,
    output logic [1:0]           grant,
    output logic                 timeout_err,
    input  logic                 clr_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN0    = 2'd1,
        OWN1    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_n;
    logic        last_owner;
    logic [31:0] wait_cnt;
    logic        req0;
    logic        req1;
    logic        own;
    logic        tmo;

    // Ops 01 and 11 are the only real requests; both have bit 0 set.
    assign req0 = m0_operation[0];
    assign req1 = m1_operation[0];
    assign own  = (state == OWN0) || (state == OWN1);
    assign tmo  = TMO_EN && own && !mem_opdone && (wait_cnt == TMO_LAST);

    // Read data is broadcast; opdone qualifies which port it belongs to.
    assign m0_rdata = data_i;
    assign m1_rdata = data_i;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Arbitration and ownership transitions.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (req0 && req1) state_n = last_owner ? OWN0 : OWN1;
                else if (req0)    state_n = OWN0;
                else if (req1)    state_n = OWN1;
            end
            OWN0:    if (tmo || !req0) state_n = RELEASE;
            OWN1:    if (tmo || !req1) state_n = RELEASE;
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Memory-side mux, grant and per-port completion routing.
    always_comb begin
        mem_operation = 2'b00;
        addr_o        = '0;
        data_o        = '0;
        grant         = 2'b00;
        m0_opdone     = 1'b0;
        m1_opdone     = 1'b0;
        unique case (state)
            OWN0: begin
                mem_operation = m0_operation;
                addr_o        = m0_addr;
                data_o        = m0_wdata;
                grant         = 2'b01;
                m0_opdone     = mem_opdone;
            end
            OWN1: begin
                mem_operation = m1_operation;
                addr_o        = m1_addr;
                data_o        = m1_wdata;
                grant         = 2'b10;
                m1_opdone     = mem_opdone;
            end
            default: ;
        endcase
    end

    // Remember who released last so the other port wins a tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= 1'b1;
        end else if (state_n == RELEASE) begin
            if (state == OWN0) last_owner <= 1'b0;
            if (state == OWN1) last_owner <= 1'b1;
        end
    end

    // Wait counter: restarts on grant and on each completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == IDLE && state_n != IDLE) begin
            wait_cnt <= '0;
        end else if (own) begin
            if (mem_opdone) wait_cnt <= '0;
            else            wait_cnt <= wait_cnt + 32'd1;
        end
    end

    // Sticky timeout flag; a fresh timeout beats a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       timeout_err <= 1'b0;
        else if (tmo)     timeout_err <= 1'b1;
        else if (clr_err) timeout_err <= 1'b0;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the cycles a granted op may wait for mem_opdone; 0 disables the timeout.
REQ-002 SHALL use data width `TYPE_BW and address width 32.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports vccd1/vssd1, inout, 1, present only under `USE_POWER_PINS.
REQ-006 SHALL have ports mN_operation (N=0,1), input, 2, requester op: 01 read, 11 write, 00/10 none.
REQ-007 SHALL have ports mN_addr, input, 32, and mN_wdata, input, `TYPE_BW, the requester address and write data.
REQ-008 SHALL have ports mN_rdata, output, `TYPE_BW, and mN_opdone, output, 1, the read data and completion pulse to requester N.
REQ-009 SHALL have ports mem_operation, output, 2; addr_o, output, 32; data_o, output, `TYPE_BW: the shared memory-side request.
REQ-010 SHALL have ports data_i, input, `TYPE_BW, and mem_opdone, input, 1: memory read data and completion.
REQ-011 SHALL have ports grant, output, 2 (one-hot owner); timeout_err, output, 1 (sticky); clr_err, input, 1.

Function
REQ-012 SHALL implement FSM states IDLE, OWN0, OWN1, RELEASE.
REQ-013 In IDLE, a port requests when its mN_operation is 01 or 11.
REQ-014 In IDLE, a single requester SHALL be granted at the next edge.
REQ-015 When both ports request in IDLE, the port that is not last_owner SHALL win; last_owner resets to 1, so port 0 wins first.
REQ-016 In OWNn, mem_operation, addr_o and data_o SHALL combinationally equal mn_operation, mn_addr and mn_wdata; grant[n]=1.
REQ-017 In IDLE and RELEASE, mem_operation=00, addr_o=0, data_o=0, grant=00.
REQ-018 mn_opdone SHALL equal mem_opdone only while in OWNn; the other port's opdone SHALL stay 0.
REQ-019 mN_rdata SHALL equal data_i for both ports at all times; validity is qualified by mN_opdone.
REQ-020 Ownership SHALL persist across consecutive transactions (burst lock) while the owner's operation remains 01 or 11, including address changes.
REQ-021 When the owner's operation is 00 or 10 at an edge, the FSM SHALL go to RELEASE, record last_owner=n, and go to IDLE on the following edge; this guarantees at least one idle bus cycle between owners.
REQ-022 Request-to-memory latency from IDLE is 1 cycle; re-arbitration after release is 2 cycles.
REQ-023 A 32-bit wait counter SHALL clear on grant and on every mem_opdone in OWNn, and increment each other cycle in OWNn.
REQ-024 If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, the arbiter SHALL set timeout_err and go to RELEASE; the owner receives no opdone.
REQ-025 timeout_err SHALL stay set until clr_err=1 at an edge; if a new timeout occurs in the same cycle, set wins.
REQ-026 mem_opdone arriving in IDLE or RELEASE SHALL be ignored.

Reset
REQ-027 While reset=0, the arbiter SHALL immediately (asynchronously) enter IDLE with mem_operation=00, addr_o=0, data_o=0, grant=00, timeout_err=0, counter=0 and last_owner=1, including mid-transaction.
REQ-028 After reset deasserts, the first arbitration SHALL occur at the first rising clk edge with reset=1.

Verification
REQ-029 m0 read at addr 0x4 with m1 idle -> grant=01 next cycle, addr_o=0x4, mem_operation=01; mem_opdone with data_i=7 -> m0_rdata=7, m0_opdone=1, m1_opdone=0.
REQ-030 Both ports request in IDLE after reset -> port 0 granted; after port 0 releases -> RELEASE cycle, then port 1 granted.
REQ-031 m0 holds op=01 while stepping addr 0..3 with four opdones -> grant stays 01 throughout; m1's request waits until m0 drives 00.
REQ-032 TIMEOUT_CYCLES=8, m1 write with no mem_opdone -> at 8 cycles timeout_err=1, grant=00, no m1_opdone; clr_err=1 -> timeout_err=0.
REQ-033 reset=0 asserted mid-write in OWN1 -> outputs zero without a clock edge; after release, port 0 wins a simultaneous request.
REQ-034 m1 drives op=10 -> not granted; mem_opdone pulse in IDLE -> no opdone to either port.
